// File: rtl/lock_pkg.sv
// Shared types and constants for the reprogrammable lock controller.
// State encoding, power-on code and timer sizing helper.
package lock_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        COLLECT = 3'd0,
        CHECK   = 3'd1,
        OPEN    = 3'd2,
        PROG    = 3'd3,
        LOCKOUT = 3'd4
    } state_e;

    localparam int               LOCK_CODE_W       = 4;
    localparam logic [LOCK_CODE_W-1:0] LOCK_DEFAULT_CODE = 4'b1011;

    // Down-counter width able to hold the longer of the two windows.
    function automatic int timer_width(input int a, input int b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

endpackage

// File: rtl/lock_code_shift.sv
// Serial-to-parallel code framer: MSB-first shift register plus bit counter.
// word_done_o flags the edge that accepts the last bit; clear_i beats shift_en_i.
module lock_code_shift #(
    parameter int CODE_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              shift_en_i,
    input  logic              clear_i,
    input  logic              bit_i,
    output logic [CODE_W-1:0] word_o,
    output logic [CODE_W-1:0] word_next_o,
    output logic              word_done_o
);

    localparam int CNT_W = $clog2(CODE_W + 1);

    logic [CODE_W-1:0] sr_q, sr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    assign word_o      = sr_q;
    assign word_next_o = (sr_q << 1) | CODE_W'(bit_i);
    assign word_done_o = shift_en_i && (cnt_q == CNT_W'(CODE_W - 1));

    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (clear_i) begin
            sr_d  = '0;
            cnt_d = '0;
        end else if (shift_en_i) begin
            sr_d  = word_next_o;
            cnt_d = word_done_o ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/lock_controller.sv
// Configurable serial lock: frames code words, compares to stored code, runs open/lockout windows.
// door_open/locked_out rise two edges after the last code bit; all outputs come straight from flops.
module lock_controller
    import lock_pkg::*;
#(
    parameter int                CODE_W         = LOCK_CODE_W,
    parameter logic [CODE_W-1:0] DEFAULT_CODE   = CODE_W'(LOCK_DEFAULT_CODE),
    parameter int                MAX_FAILS      = 3,
    parameter int                OPEN_CYCLES    = 8,
    parameter int                LOCKOUT_CYCLES = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           bit_valid,
    input  logic                           bit_in,
    input  logic                           prog_req,
    output logic                           door_open,
    output logic                           locked_out,
    output logic                           prog_active,
    output logic [$clog2(MAX_FAILS+1)-1:0] fail_count
);

    localparam int FC_W  = $clog2(MAX_FAILS + 1);
    localparam int TMR_W = timer_width(OPEN_CYCLES, LOCKOUT_CYCLES);

    state_e            state_q, state_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic [FC_W-1:0]   fail_q, fail_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic              door_q, lock_q, prog_q;

    logic              shift_en, shift_clear, word_done;
    logic [CODE_W-1:0] word, word_next;

    assign shift_en    = bit_valid && (state_q == COLLECT || state_q == PROG);
    assign shift_clear = (state_d != state_q) && (state_d == COLLECT || state_d == PROG);

    lock_code_shift #(.CODE_W(CODE_W)) u_shift (
        .clk         (clk),
        .reset       (reset),
        .shift_en_i  (shift_en),
        .clear_i     (shift_clear),
        .bit_i       (bit_in),
        .word_o      (word),
        .word_next_o (word_next),
        .word_done_o (word_done)
    );

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        fail_d  = fail_q;
        timer_d = timer_q;
        case (state_q)
            COLLECT: if (word_done) state_d = CHECK;
            CHECK: begin
                if (word == code_q) begin
                    state_d = OPEN;
                    fail_d  = '0;
                end else if (int'(fail_q) + 1 < MAX_FAILS) begin
                    state_d = COLLECT;
                    fail_d  = fail_q + FC_W'(1);
                end else begin
                    state_d = LOCKOUT;
                    fail_d  = FC_W'(MAX_FAILS);
                end
            end
            OPEN: begin
                if (prog_req)                      state_d = PROG;
                else if (timer_q == TMR_W'(1))     state_d = COLLECT;
                else                               timer_d = timer_q - TMR_W'(1);
            end
            PROG: begin
                if (word_done) begin
                    code_d  = word_next;
                    state_d = COLLECT;
                end
            end
            LOCKOUT: begin
                if (timer_q == TMR_W'(1)) begin
                    state_d = COLLECT;
                    fail_d  = '0;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            default: state_d = COLLECT;
        endcase
        if (state_d == OPEN && state_q != OPEN)       timer_d = TMR_W'(OPEN_CYCLES);
        if (state_d == LOCKOUT && state_q != LOCKOUT) timer_d = TMR_W'(LOCKOUT_CYCLES);
    end

    // Window outputs trail the state by one edge, giving the two-edge unlock latency;
    // a programming request cuts the open window on the same edge PROG is entered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= COLLECT;
            code_q  <= DEFAULT_CODE;
            fail_q  <= '0;
            timer_q <= '0;
            door_q  <= 1'b0;
            lock_q  <= 1'b0;
            prog_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            fail_q  <= fail_d;
            timer_q <= timer_d;
            door_q  <= (state_q == OPEN) && !prog_req;
            lock_q  <= (state_q == LOCKOUT);
            prog_q  <= (state_d == PROG);
        end
    end

    assign door_open   = door_q;
    assign locked_out  = lock_q;
    assign prog_active = prog_q;
    assign fail_count  = fail_q;

endmodule

// File: tb/tb_lock_controller.sv
// Directed bench for lock_controller: unlock, failures/lockout, reprogramming, resets, full code sweep.
module tb_lock_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       bit_valid;
    logic       bit_in;
    logic       prog_req;
    logic       door_open;
    logic       locked_out;
    logic       prog_active;
    logic [1:0] fail_count;

    int vectors    = 0;
    int miscompares = 0;

    lock_controller dut (
        .clk         (clk),
        .reset       (reset),
        .bit_valid   (bit_valid),
        .bit_in      (bit_in),
        .prog_req    (prog_req),
        .door_open   (door_open),
        .locked_out  (locked_out),
        .prog_active (prog_active),
        .fail_count  (fail_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input int gap);
        repeat (gap) begin
            bit_in = 1'($urandom_range(0, 1));
            tick();
        end
        bit_valid = 1'b1;
        bit_in    = b;
        tick();
        bit_valid = 1'b0;
    endtask

    task automatic send_code(input logic [3:0] c, input int maxgap);
        for (int i = 3; i >= 0; i--)
            send_bit(c[i], int'($urandom_range(0, maxgap)));
    endtask

    // Called just after the edge that accepted the last code bit.
    task automatic expect_open(input string tag);
        tick();
        check({tag, " open_lat1"}, {7'd0, door_open}, 8'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check({tag, " open_win"}, {7'd0, door_open}, 8'd1);
        end
        tick();
        check({tag, " open_end"}, {7'd0, door_open}, 8'd0);
        check({tag, " open_fc"}, {6'd0, fail_count}, 8'd0);
    endtask

    task automatic expect_fail(input string tag, input int exp_fc);
        tick();
        check({tag, " fail_fc"}, {6'd0, fail_count}, 8'(exp_fc));
        check({tag, " fail_door"}, {7'd0, door_open | locked_out}, 8'd0);
    endtask

    task automatic expect_lockout(input string tag);
        logic [3:0] noise;
        noise = 4'b1011;
        tick();
        check({tag, " lock_fc"}, {6'd0, fail_count}, 8'd3);
        check({tag, " lock_lat1"}, {7'd0, locked_out}, 8'd0);
        for (int i = 0; i < 16; i++) begin
            if (i < 4) begin
                bit_valid = 1'b1;
                bit_in    = noise[3-i];
            end
            tick();
            bit_valid = 1'b0;
            check({tag, " lock_win"}, {7'd0, locked_out}, 8'd1);
        end
        tick();
        check({tag, " lock_end"}, {7'd0, locked_out}, 8'd0);
        check({tag, " lock_fc_clr"}, {6'd0, fail_count}, 8'd0);
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        #2;
        check("rst_async_door", {7'd0, door_open}, 8'd0);
        check("rst_async_prog", {7'd0, prog_active}, 8'd0);
        check("rst_async_fc", {6'd0, fail_count}, 8'd0);
        reset = 1'b1;
        tick();
    endtask

    initial begin
        int fails;
        reset     = 1'b0;
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        prog_req  = 1'b0;
        tick();
        tick();
        check("rst_door", {7'd0, door_open}, 8'd0);
        check("rst_lock", {7'd0, locked_out}, 8'd0);
        check("rst_prog", {7'd0, prog_active}, 8'd0);
        check("rst_fc", {6'd0, fail_count}, 8'd0);
        reset = 1'b1;
        tick();
        check("post_rst_door", {7'd0, door_open}, 8'd0);

        send_code(4'b1011, 0);
        expect_open("default");

        send_code(4'b0000, 0);
        expect_fail("f1", 1);
        send_code(4'b0001, 0);
        expect_fail("f2", 2);
        send_code(4'b0010, 0);
        expect_lockout("lk");
        send_code(4'b1011, 0);
        expect_open("after_lk");

        send_code(4'b0000, 0);
        expect_fail("recov", 1);
        send_code(4'b1011, 0);
        expect_open("recov");

        // Reprogram to 0110, cutting the open window in its third cycle.
        send_code(4'b1011, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            check("prg_door_pre", {7'd0, door_open}, 8'd1);
        end
        prog_req = 1'b1;
        tick();
        prog_req = 1'b0;
        check("prg_door_cut", {7'd0, door_open}, 8'd0);
        check("prg_act_rise", {7'd0, prog_active}, 8'd1);
        send_bit(1'b0, 0);
        send_bit(1'b1, 1);
        send_bit(1'b1, 0);
        check("prg_act_hold", {7'd0, prog_active}, 8'd1);
        send_bit(1'b0, 2);
        check("prg_act_fall", {7'd0, prog_active}, 8'd0);
        check("prg_door_off", {7'd0, door_open}, 8'd0);
        send_code(4'b1011, 0);
        expect_fail("old_code", 1);
        send_code(4'b0110, 0);
        expect_open("new_code");

        // Partial entry discarded by reset; reset also restores the default code.
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        pulse_reset();
        send_code(4'b1011, 0);
        expect_open("partial_rst");

        // Reset during programming loses the half-entered code.
        send_code(4'b1011, 0);
        tick();
        tick();
        prog_req = 1'b1;
        tick();
        prog_req = 1'b0;
        check("mid_prg_act", {7'd0, prog_active}, 8'd1);
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        pulse_reset();
        check("mid_prg_act_clr", {7'd0, prog_active}, 8'd0);
        send_code(4'b0110, 0);
        expect_fail("mid_prg_old", 1);
        send_code(4'b1011, 0);
        expect_open("mid_prg_dflt");

        // Sweep all codes with idle gaps; every third consecutive miss locks out.
        fails = 0;
        for (int c = 0; c < 16; c++) begin
            send_code(4'(c), 2);
            if (c == 11) begin
                expect_open("sweep");
                fails = 0;
            end else begin
                fails++;
                if (fails == 3) begin
                    expect_lockout("sweep");
                    fails = 0;
                end else begin
                    expect_fail("sweep", fails);
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lock_controller.md
Name: lock_controller

Overview:
- Sequencing controller for the serial password-detector datapath. It frames serial code bits into CODE_W-bit words and compares each word against a stored, reprogrammable code.
- It opens a timed unlock window, counts failed attempts and enforces a lockout period.
- Sits between the keypad/serial front end and the door actuator. It replaces the fixed-code FSM with a configurable one.

Parameters:
- CODE_W, 4, bits per code word (MSB entered first)
- DEFAULT_CODE, 4'b1011, stored code after reset
- MAX_FAILS, 3, consecutive mismatches that trigger lockout (≥1)
- OPEN_CYCLES, 8, clock cycles door_open stays high (≥1)
- LOCKOUT_CYCLES, 16, clock cycles locked_out stays high (≥1)

Ports:
- clk, input, 1, system clock, rising edge
- reset, input, 1, asynchronous active-low reset; 0 resets the block
- bit_valid, input, 1, bit_in is sampled on this clock edge
- bit_in, input, 1, serial code bit
- prog_req, input, 1, request to reprogram the code; honoured only in OPEN
- door_open, output, 1, unlock window active
- locked_out, output, 1, lockout active; input bits are ignored
- prog_active, output, 1, new code entry in progress
- fail_count, output, $clog2(MAX_FAILS+1), consecutive mismatches so far

Behaviour:
- Reset (reset=0, asynchronous):
  - state=COLLECT, shift register=0, bit counter=0, stored code=DEFAULT_CODE.
  - All timers cleared; door_open=0, locked_out=0, prog_active=0, fail_count=0.
- State register holds one of COLLECT, CHECK, OPEN, PROG, LOCKOUT. All outputs are registered or decoded from state only; there is no combinational path from any input.
- COLLECT:
  - Each edge with bit_valid=1 shifts bit_in into the LSB and increments the bit counter.
  - On the edge that accepts bit CODE_W, the state goes to CHECK and the counter clears.
- CHECK (exactly 1 cycle; bit_valid ignored):
  - Match: go to OPEN and clear fail_count.
  - Mismatch with fail_count+1 < MAX_FAILS: increment fail_count and go to COLLECT.
  - Mismatch with fail_count+1 == MAX_FAILS: set fail_count to MAX_FAILS and go to LOCKOUT.
- Latency: the last bit is accepted at edge N; door_open or locked_out rises at edge N+2.
- OPEN:
  - door_open=1 for exactly OPEN_CYCLES cycles, then the state goes to COLLECT.
  - bit_valid is ignored in OPEN.
  - prog_req=1 at any edge in OPEN goes to PROG immediately. door_open drops, and the remaining open time is abandoned.
- PROG:
  - prog_active=1; bits shift in exactly as in COLLECT.
  - On the edge that accepts bit CODE_W, the stored code is replaced with the shifted word, the state goes to COLLECT, and prog_active drops.
  - prog_req is ignored once in PROG.
- LOCKOUT:
  - locked_out=1 for exactly LOCKOUT_CYCLES cycles; bit_valid and prog_req are ignored.
  - On exit, fail_count=0 and the state goes to COLLECT with an empty shift register.
- Partial entry: bits received before a state change to COLLECT are always discarded. The counter is cleared on every entry to COLLECT or PROG.
- Timers are down-counters loaded on state entry, width $clog2(max(OPEN_CYCLES,LOCKOUT_CYCLES)+1). No wrap: exit occurs at count 1.
- Reset mid-operation (any state, including mid-PROG) restores DEFAULT_CODE; a partially programmed code is lost.

Decomposition:
- Package lock_pkg:
  - state enum (COLLECT, CHECK, OPEN, PROG, LOCKOUT) and state width constant.
  - DEFAULT_CODE and timer-width helper constant.
- Sub-module lock_code_shift:
  - CODE_W shift register plus bit counter, with shift_en, clear and word_done outputs.
  - Shared by the COLLECT and PROG paths.
- Top level holds the FSM, the stored-code register, fail_count and the single shared timer.

Test Plan:
- Reset asserted then released → door_open=0, locked_out=0, prog_active=0, fail_count=0. Entering 1011 → door_open high 2 cycles after the 4th bit for exactly 8 cycles.
- Enter 0000, 0001, 0010 → fail_count goes 1, 2, then locked_out=1 for 16 cycles. Bits 1011 sent during lockout are ignored. After lockout fail_count=0, and 1011 opens.
- Enter 1011, then pulse prog_req in the 3rd open cycle, then 0110 → door_open drops, prog_active high until the 4th bit. Then 1011 fails (fail_count=1) and 0110 opens.
- Enter 0000 then 1011 → fail_count=1 then 0, and door_open asserts.
- Enter 10, assert reset, release, enter 1011 → opens exactly after 4 new bits, with no carry-over of the partial entry. Assert reset mid-PROG → stored code is 1011 again.
- Exhaustive sweep of all 16 codes, with bit_valid gaps between bits → only 1011 opens. Lockout triggers on every 3rd consecutive mismatch.
